// File: rtl/rmw_tag_scheduler.sv
// Tagged read-modify-write issue controller: allocates lookup tags, parks per-tag
// context until the out-of-order table response returns, then emits the write-back.
module rmw_tag_scheduler #(
  parameter  int IN_FLIGHT_N = 16,
  parameter  int ID_W        = 16,
  parameter  int WORD_W      = 32,
  localparam int TAG_W       = $clog2(IN_FLIGHT_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_vld,
  input  logic [ID_W-1:0]   issue_id,
  input  logic [WORD_W-1:0] issue_imm,
  input  logic [1:0]        issue_op,
  output logic              issue_rdy,
  output logic              tbl_req_vld,
  output logic [TAG_W-1:0]  tbl_req_tag,
  output logic [ID_W-1:0]   tbl_req_id,
  input  logic              tbl_req_rdy,
  input  logic              tbl_rsp_vld,
  input  logic [TAG_W-1:0]  tbl_rsp_tag,
  input  logic [WORD_W-1:0] tbl_rsp_dat,
  output logic              wr_vld,
  output logic [ID_W-1:0]   wr_id,
  output logic [WORD_W-1:0] wr_dat,
  output logic [TAG_W:0]    inflight_cnt,
  output logic              err
);
  typedef enum logic [1:0] {OP_NOP = 2'b00, OP_ADDI = 2'b01, OP_SUBI = 2'b10, OP_MOVI = 2'b11} op_e;

  logic [IN_FLIGHT_N-1:0]             vld_q, vld_d;
  logic [IN_FLIGHT_N-1:0][ID_W-1:0]   id_q, id_d;
  logic [IN_FLIGHT_N-1:0][WORD_W-1:0] imm_q, imm_d;
  logic [IN_FLIGHT_N-1:0][1:0]        op_q, op_d;
  logic                               req_vld_q, req_vld_d;
  logic [TAG_W-1:0]                   req_tag_q, req_tag_d;
  logic [ID_W-1:0]                    req_id_q, req_id_d;
  logic                               wr_vld_q, wr_vld_d;
  logic [ID_W-1:0]                    wr_id_q, wr_id_d;
  logic [WORD_W-1:0]                  wr_dat_q, wr_dat_d;
  logic [TAG_W:0]                     cnt_q, cnt_d;
  logic                               err_q, err_d;

  logic             any_free, hazard, req_stall, accept, rsp_hit;
  logic [TAG_W-1:0] alloc_tag;

  always_comb begin
    any_free  = 1'b0;
    hazard    = 1'b0;
    alloc_tag = '0;
    // Descending scan leaves the lowest free index in alloc_tag.
    for (int i = IN_FLIGHT_N - 1; i >= 0; i--) begin
      if (!vld_q[i]) begin
        any_free  = 1'b1;
        alloc_tag = TAG_W'(i);
      end
      if (vld_q[i] && id_q[i] == issue_id) hazard = 1'b1;
    end
    req_stall = req_vld_q & ~tbl_req_rdy;
    issue_rdy = (issue_op == OP_NOP) | (any_free & ~hazard & ~req_stall);
    accept    = issue_vld & issue_rdy & (issue_op != OP_NOP);
    rsp_hit   = tbl_rsp_vld & vld_q[tbl_rsp_tag];

    vld_d = vld_q;
    id_d  = id_q;
    imm_d = imm_q;
    op_d  = op_q;
    if (rsp_hit) vld_d[tbl_rsp_tag] = 1'b0;
    if (accept) begin
      vld_d[alloc_tag] = 1'b1;
      id_d[alloc_tag]  = issue_id;
      imm_d[alloc_tag] = issue_imm;
      op_d[alloc_tag]  = issue_op;
    end

    req_vld_d = req_vld_q & ~tbl_req_rdy;
    req_tag_d = req_tag_q;
    req_id_d  = req_id_q;
    if (accept) begin
      req_vld_d = 1'b1;
      req_tag_d = alloc_tag;
      req_id_d  = issue_id;
    end

    wr_vld_d = rsp_hit;
    wr_id_d  = wr_id_q;
    wr_dat_d = wr_dat_q;
    if (rsp_hit) begin
      wr_id_d = id_q[tbl_rsp_tag];
      case (op_e'(op_q[tbl_rsp_tag]))
        OP_ADDI: wr_dat_d = tbl_rsp_dat + imm_q[tbl_rsp_tag];
        OP_SUBI: wr_dat_d = tbl_rsp_dat - imm_q[tbl_rsp_tag];
        default: wr_dat_d = imm_q[tbl_rsp_tag];
      endcase
    end

    err_d = err_q | (tbl_rsp_vld & ~vld_q[tbl_rsp_tag]);

    cnt_d = '0;
    for (int i = 0; i < IN_FLIGHT_N; i++) cnt_d = cnt_d + (TAG_W+1)'(vld_d[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      req_vld_q <= 1'b0;
      req_tag_q <= '0;
      req_id_q  <= '0;
      wr_vld_q  <= 1'b0;
      wr_id_q   <= '0;
      wr_dat_q  <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      vld_q     <= vld_d;
      req_vld_q <= req_vld_d;
      req_tag_q <= req_tag_d;
      req_id_q  <= req_id_d;
      wr_vld_q  <= wr_vld_d;
      wr_id_q   <= wr_id_d;
      wr_dat_q  <= wr_dat_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // Context payload is qualified by vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    id_q  <= id_d;
    imm_q <= imm_d;
    op_q  <= op_d;
  end

  assign tbl_req_vld  = req_vld_q;
  assign tbl_req_tag  = req_tag_q;
  assign tbl_req_id   = req_id_q;
  assign wr_vld       = wr_vld_q;
  assign wr_id        = wr_id_q;
  assign wr_dat       = wr_dat_q;
  assign inflight_cnt = cnt_q;
  assign err          = err_q;
endmodule

// File: tb/tb_rmw_tag_scheduler.sv
// Scoreboard bench: directed commands push expected requests/write-backs; a negedge
// monitor pops and compares whenever the scheduler hands one out.
module tb_rmw_tag_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        issue_vld;
  logic [15:0] issue_id;
  logic [31:0] issue_imm;
  logic [1:0]  issue_op;
  logic        issue_rdy;
  logic        tbl_req_vld;
  logic [3:0]  tbl_req_tag;
  logic [15:0] tbl_req_id;
  logic        tbl_req_rdy;
  logic        tbl_rsp_vld;
  logic [3:0]  tbl_rsp_tag;
  logic [31:0] tbl_rsp_dat;
  logic        wr_vld;
  logic [15:0] wr_id;
  logic [31:0] wr_dat;
  logic [4:0]  inflight_cnt;
  logic        err;

  int total = 0;
  int bad   = 0;
  logic [19:0] req_q[$];
  logic [47:0] wr_q[$];

  always #5 clk = ~clk;

  rmw_tag_scheduler dut (
    .clk(clk), .rst(rst),
    .issue_vld(issue_vld), .issue_id(issue_id), .issue_imm(issue_imm), .issue_op(issue_op),
    .issue_rdy(issue_rdy),
    .tbl_req_vld(tbl_req_vld), .tbl_req_tag(tbl_req_tag), .tbl_req_id(tbl_req_id),
    .tbl_req_rdy(tbl_req_rdy),
    .tbl_rsp_vld(tbl_rsp_vld), .tbl_rsp_tag(tbl_rsp_tag), .tbl_rsp_dat(tbl_rsp_dat),
    .wr_vld(wr_vld), .wr_id(wr_id), .wr_dat(wr_dat),
    .inflight_cnt(inflight_cnt), .err(err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of issue; checks readiness and records the expected request.
  task automatic issue(input logic [1:0] op, input logic [15:0] id, input logic [31:0] imm,
                       input bit exp_rdy, input logic [3:0] exp_tag);
    issue_vld = 1'b1; issue_op = op; issue_id = id; issue_imm = imm;
    #1;
    chk("issue_rdy", {63'd0, issue_rdy}, {63'd0, exp_rdy});
    if (exp_rdy && op != 2'b00) req_q.push_back({exp_tag, id});
    tick();
    issue_vld = 1'b0; issue_op = 2'b00;
  endtask

  task automatic respond(input logic [3:0] tag, input logic [31:0] dat,
                         input bit exp_wr, input logic [15:0] exp_id, input logic [31:0] exp_dat);
    tbl_rsp_vld = 1'b1; tbl_rsp_tag = tag; tbl_rsp_dat = dat;
    if (exp_wr) wr_q.push_back({exp_id, exp_dat});
    tick();
    tbl_rsp_vld = 1'b0;
  endtask

  // Monitor: consumes expectations only when the DUT actually produces an output.
  always @(negedge clk) begin
    if (!rst) begin
      if (tbl_req_vld && tbl_req_rdy) begin
        if (req_q.size() == 0) chk("unexpected_req", {44'd0, tbl_req_tag, tbl_req_id}, 64'hDEAD);
        else begin
          logic [19:0] e;
          e = req_q.pop_front();
          chk("req_tag", {60'd0, tbl_req_tag}, {60'd0, e[19:16]});
          chk("req_id",  {48'd0, tbl_req_id},  {48'd0, e[15:0]});
        end
      end
      if (wr_vld) begin
        if (wr_q.size() == 0) chk("unexpected_wr", {16'd0, wr_id, wr_dat}, 64'hDEAD);
        else begin
          logic [47:0] e;
          e = wr_q.pop_front();
          chk("wr_id",  {48'd0, wr_id},  {48'd0, e[47:32]});
          chk("wr_dat", {32'd0, wr_dat}, {32'd0, e[31:0]});
        end
      end
    end
  end

  initial begin
    logic [3:0]  htag;
    logic [15:0] hid;
    rst = 1'b1; issue_vld = 1'b0; issue_id = '0; issue_imm = '0; issue_op = 2'b00;
    tbl_req_rdy = 1'b1; tbl_rsp_vld = 1'b0; tbl_rsp_tag = '0; tbl_rsp_dat = '0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_cnt", {59'd0, inflight_cnt}, 64'd0);
    chk("rst_req_vld", {63'd0, tbl_req_vld}, 64'd0);
    chk("rst_wr_vld", {63'd0, wr_vld}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    issue_op = 2'b01; #1;
    chk("rst_issue_rdy", {63'd0, issue_rdy}, 64'd1);
    issue_op = 2'b00;
    tick();

    // Basic ADDI round trip.
    issue(2'b01, 16'd5, 32'd3, 1'b1, 4'd0);
    tick();
    respond(4'd0, 32'd10, 1'b1, 16'd5, 32'd13);
    tick();
    chk("cnt_after_first", {59'd0, inflight_cnt}, 64'd0);

    // Fill all tags, then free tag 7 and reuse it.
    for (int i = 0; i < 16; i++) issue(2'b01, 16'(100 + i), 32'(i), 1'b1, 4'(i));
    chk("cnt_full", {59'd0, inflight_cnt}, 64'd16);
    issue(2'b01, 16'd200, 32'd0, 1'b0, 4'd0);
    respond(4'd7, 32'd50, 1'b1, 16'd107, 32'd57);
    issue(2'b01, 16'd300, 32'd0, 1'b1, 4'd7);
    for (int i = 0; i < 16; i++) begin
      if (i == 7) respond(4'd7, 32'd0, 1'b1, 16'd300, 32'd0);
      else        respond(4'(i), 32'd0, 1'b1, 16'(100 + i), 32'(i));
    end
    tick();
    chk("cnt_drained", {59'd0, inflight_cnt}, 64'd0);

    // Arithmetic wrap and MOVI.
    issue(2'b10, 16'd20, 32'd1, 1'b1, 4'd0);
    respond(4'd0, 32'd0, 1'b1, 16'd20, 32'hFFFF_FFFF);
    issue(2'b01, 16'd21, 32'd1, 1'b1, 4'd0);
    respond(4'd0, 32'hFFFF_FFFF, 1'b1, 16'd21, 32'd0);
    issue(2'b11, 16'd22, 32'hA5, 1'b1, 4'd0);
    respond(4'd0, 32'h1234, 1'b1, 16'd22, 32'hA5);

    // Same-id hazard: stalls through the response cycle, accepted the cycle after.
    issue(2'b01, 16'd9, 32'd2, 1'b1, 4'd0);
    issue(2'b01, 16'd9, 32'd2, 1'b0, 4'd0);
    issue_vld = 1'b1; issue_op = 2'b01; issue_id = 16'd9; issue_imm = 32'd2;
    tbl_rsp_vld = 1'b1; tbl_rsp_tag = 4'd0; tbl_rsp_dat = 32'd4;
    wr_q.push_back({16'd9, 32'd6});
    #1;
    chk("hazard_rsp_cycle_rdy", {63'd0, issue_rdy}, 64'd0);
    tick();
    tbl_rsp_vld = 1'b0;
    #1;
    chk("hazard_next_rdy", {63'd0, issue_rdy}, 64'd1);
    req_q.push_back({4'd0, 16'd9});
    tick();
    issue_vld = 1'b0; issue_op = 2'b00;
    respond(4'd0, 32'd6, 1'b1, 16'd9, 32'd8);

    // Request backpressure: held stable, non-NOP blocked, NOP still consumed.
    tbl_req_rdy = 1'b0;
    issue(2'b01, 16'd40, 32'd1, 1'b1, 4'd0);
    htag = tbl_req_tag; hid = tbl_req_id;
    for (int c = 0; c < 5; c++) begin
      chk("bp_req_vld", {63'd0, tbl_req_vld}, 64'd1);
      chk("bp_req_tag", {60'd0, tbl_req_tag}, 64'd0);
      chk("bp_req_id",  {48'd0, tbl_req_id}, 64'd40);
      chk("bp_stable", {44'd0, tbl_req_tag, tbl_req_id}, {44'd0, htag, hid});
      if (c == 2) issue(2'b00, 16'd50, 32'd0, 1'b1, 4'd0);
      else        issue(2'b01, 16'd41, 32'd0, 1'b0, 4'd0);
    end
    tbl_req_rdy = 1'b1;
    tick();
    chk("bp_released", {63'd0, tbl_req_vld}, 64'd0);
    respond(4'd0, 32'd5, 1'b1, 16'd40, 32'd6);
    tick();

    // Stray response: no write, sticky err.
    chk("err_before", {63'd0, err}, 64'd0);
    respond(4'd3, 32'd77, 1'b0, 16'd0, 32'd0);
    chk("err_set", {63'd0, err}, 64'd1);
    tick(); tick();
    chk("err_sticky", {63'd0, err}, 64'd1);

    // Reset with tags in flight.
    for (int i = 0; i < 4; i++) issue(2'b01, 16'(60 + i), 32'd0, 1'b1, 4'(i));
    tick();
    chk("cnt_four", {59'd0, inflight_cnt}, 64'd4);
    rst = 1'b1;
    tick();
    chk("rst2_cnt", {59'd0, inflight_cnt}, 64'd0);
    chk("rst2_outs", {6'd0, tbl_req_vld, tbl_req_tag, tbl_req_id, wr_vld, wr_id, err},
        64'd0);
    chk("rst2_wr_dat", {32'd0, wr_dat}, 64'd0);
    rst = 1'b0;
    respond(4'd1, 32'd3, 1'b0, 16'd0, 32'd0);
    chk("late_rsp_err", {63'd0, err}, 64'd1);
    chk("late_rsp_cnt", {59'd0, inflight_cnt}, 64'd0);

    for (int c = 0; c < 20 && (req_q.size() != 0 || wr_q.size() != 0); c++) tick();
    chk("req_q_empty", 64'(req_q.size()), 64'd0);
    chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rmw_tag_scheduler.md
# rmw_tag_scheduler

Issue-side controller for the long-latency read-modify-write path. It accepts RMW commands (id, immediate, op), allocates one of IN_FLIGHT_N tags to each, and issues a tagged lookup to the table (TBL). It holds per-tag context until the out-of-order lookup response returns, then computes the modified word and emits the write-back. It also blocks read-after-write hazards by refusing a second command to an id that is already in flight.

## Interface
Parameters:
- IN_FLIGHT_N, 16, maximum concurrent outstanding lookups (power of two); TAG_W = clog2(IN_FLIGHT_N)
- ID_W, 16, command id width
- WORD_W, 32, data/immediate width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- issue_vld  in  1  command valid
- issue_id  in  ID_W  target id
- issue_imm  in  WORD_W  immediate operand
- issue_op  in  2  op: 00 NOP, 01 ADDI, 10 SUBI, 11 MOVI
- issue_rdy  out  1  command accepted when issue_vld & issue_rdy
- tbl_req_vld  out  1  lookup request valid
- tbl_req_tag  out  TAG_W  tag of request
- tbl_req_id  out  ID_W  id to look up
- tbl_req_rdy  in  1  TBL accepts request
- tbl_rsp_vld  in  1  lookup response valid (always accepted)
- tbl_rsp_tag  in  TAG_W  tag of response
- tbl_rsp_dat  in  WORD_W  current word for that id
- wr_vld  out  1  write-back valid (always accepted downstream)
- wr_id  out  ID_W  write-back id
- wr_dat  out  WORD_W  write-back data
- inflight_cnt  out  TAG_W+1  number of allocated tags
- err  out  1  sticky: response received for an unallocated tag

## Operation
- Context table: IN_FLIGHT_N entries {vld, id, imm, op}; free vector = ~vld.
- issue_rdy = any free tag & no valid entry with id == issue_id & !(tbl_req_vld & !tbl_req_rdy).
- NOP: when issue_vld, issue_rdy is 1 regardless of tag/hazard/backpressure; the command is consumed and dropped (no tag, no request, no write).
- Accept of non-NOP: allocate the lowest-index free tag; set entry vld, store id/imm/op; load the request register {tbl_req_vld=1, tag, id}.
- Request register holds stable until tbl_req_rdy; it clears on a handshake unless reloaded by a same-cycle accept.
- Response: the entry at tbl_rsp_tag computes the result, which is registered to wr_*. The entry vld clears at the same edge.
  - ADDI: dat + imm, modulo 2^WORD_W.
  - SUBI: dat - imm, modulo 2^WORD_W (wraps below zero).
  - MOVI: imm (dat ignored).
- Response for a tag with vld=0: no write, no state change, err set until rst.
- Hazard check uses entry vld before this cycle's response clears it. A same-id command stalls in the cycle of the response and is accepted the following cycle.
- A tag freed by a response is allocatable from the next cycle, not the same cycle.
- Simultaneous accept and response on different tags: both take effect. inflight_cnt is unchanged net.
- inflight_cnt = popcount(vld), registered.
- Reset: all entries invalid. tbl_req_vld=0, wr_vld=0, err=0, inflight_cnt=0. tbl_req_tag/id and wr_id/dat = 0. issue_rdy is 1 when rst is deasserted. Reset mid-operation discards all context; late responses after reset set err.

## Timing
- Accept at cycle t -> tbl_req_vld high at t+1.
- Response at cycle r -> wr_vld high for exactly one cycle at r+1; tag free at r+1.
- Throughput: one accept and one response per cycle. Back-to-back accepts with tbl_req_rdy=1 produce consecutive requests.
- With tbl_req_rdy low, at most one request is held and issue_rdy is low (NOP excepted).
- Full condition: inflight_cnt == IN_FLIGHT_N -> issue_rdy=0 for non-NOP.
- No combinational path from tbl_rsp_* to wr_*. issue_rdy is combinational from issue_id and state.

## Test plan
- Reset, ADDI id=5 imm=3; respond tag 0 dat=10 -> tbl_req tag0 id5 at t+1; wr_id=5, wr_dat=13 one cycle after response.
- Issue 16 ADDIs with distinct ids, tbl_req_rdy=1 -> tags 0..15 in order, inflight_cnt=16, issue_rdy=0; respond tag 7 -> next accept gets tag 7.
- SUBI imm=1 on dat=0 -> wr_dat=0xFFFFFFFF. ADDI imm=1 on dat=0xFFFFFFFF -> wr_dat=0. MOVI imm=0xA5 on dat=0x1234 -> wr_dat=0xA5.
- Issue id=9 twice -> second stalls. Respond to first with dat=4 (ADDI imm=2) -> second accepted the cycle after the response. Its request is issued next; responding dat=6 yields wr_dat=8.
- Hold tbl_req_rdy=0 for 5 cycles after an accept -> tbl_req_* stable, issue_rdy=0. NOP still consumed with no request. Release -> single handshake.
- Response for unallocated tag 3 -> no wr_vld, err=1 until rst. Assert rst with 4 tags in flight -> inflight_cnt=0, all outputs zero next cycle.
